// File: rtl/booth_pkg.sv
// booth_pkg: shared state, mode and partial-product select types; BOOTH_RADIX4_EN selects radix-4 recoding
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [1:0] MODE_UNS = 2'd0;
  localparam logic [1:0] MODE_BB  = 2'd1;
  localparam logic [1:0] MODE_AA  = 2'd2;
  localparam logic [1:0] MODE_AB  = 2'd3;
`ifdef BOOTH_RADIX4_EN
  typedef enum logic [2:0] {PP_ZERO, PP_POS, PP_NEG, PP_POS2, PP_NEG2} pp_sel_t;
  localparam int SHIFT = 2;
`else
  typedef enum logic [1:0] {PP_ZERO, PP_POS, PP_NEG} pp_sel_t;
  localparam int SHIFT = 1;
`endif
endpackage

// File: rtl/booth_recode.sv
// booth_recode: maps the multiplier bit group {q[SHIFT-1:0], q_prev} to a partial-product select (BOOTH_RADIX4_EN adds +-2M)
module booth_recode
  import booth_pkg::*;
(
  input  logic [SHIFT:0] grp,
  output pp_sel_t        sel
);
`ifdef BOOTH_RADIX4_EN
  always_comb
    sel = (grp == 3'b000 || grp == 3'b111) ? PP_ZERO :
          (grp == 3'b011) ? PP_POS2 :
          (grp == 3'b100) ? PP_NEG2 :
          grp[2] ? PP_NEG : PP_POS;
`else
  always_comb
    sel = (grp[1] == grp[0]) ? PP_ZERO : grp[1] ? PP_NEG : PP_POS;
`endif
endmodule

// File: rtl/booth_mpy_seq.sv
// booth_mpy_seq: sequential Booth multiplier, one recode/add/shift step per cycle; BOOTH_RADIX4_EN halves the step count
module booth_mpy_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               busy,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid
);
  localparam int E    = WIDTH + 2;
  localparam int AW   = E + 2;
  localparam int ITER = E / SHIFT;
  localparam int CW   = $clog2(ITER + 1);
  state_t               state, state_n;
  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] acc, mx, pp, sum;
  logic [E-1:0]         m, q;
  logic                 qm, sgn;
  logic [AW+E:0]        nxt;
  logic [WIDTH-1:0]     mc_src, mp_src;
  pp_sel_t              sel;
  booth_recode u_recode (
    .grp({q[SHIFT-1:0], qm}),
    .sel(sel)
  );
  always_comb begin
    sgn    = mode != MODE_UNS;
    mc_src = (mode == MODE_BB) ? in_b : in_a;
    mp_src = (mode == MODE_AA) ? in_a : in_b;
    mx     = {{2{m[E-1]}}, m};
    pp     = (sel == PP_POS) ? mx : (sel == PP_NEG) ? -mx :
`ifdef BOOTH_RADIX4_EN
             (sel == PP_POS2) ? (mx <<< 1) : (sel == PP_NEG2) ? -(mx <<< 1) :
`endif
             '0;
    sum    = acc + pp;
    // whole {acc, q, q_prev} shifts arithmetically so the product keeps its sign
    nxt    = $signed({sum, q, qm}) >>> SHIFT;
  end
  always_comb begin
    state_n   = state;
    state_n   = (state == IDLE) ? (start ? CALC : IDLE) :
                (state == CALC) ? ((cnt == CW'(1)) ? DONE : CALC) : IDLE;
    busy      = state != IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      m   <= '0;
      q   <= '0;
      qm  <= 1'b0;
      out <= '0;
    end else if (state == IDLE && start) begin
      cnt <= CW'(ITER);
      acc <= '0;
      m   <= {{2{sgn & mc_src[WIDTH-1]}}, mc_src};
      q   <= {{2{sgn & mp_src[WIDTH-1]}}, mp_src};
      qm  <= 1'b0;
    end else if (state == CALC) begin
      cnt <= cnt - 1'b1;
      acc <= nxt[AW+E:E+1];
      q   <= nxt[E:1];
      qm  <= nxt[0];
      if (cnt == CW'(1)) out <= nxt[2*WIDTH:1];
    end
endmodule

// File: tb/tb_booth_mpy_seq.sv
// tb_booth_mpy_seq: directed and random checks of booth_mpy_seq against a plain-arithmetic product model
module tb_booth_mpy_seq;
  localparam int W = 32;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = (W + 2) / 2;
`else
  localparam int ITER = W + 2;
`endif
  logic CLK = 1'b0;
  logic reset, start, busy, out_valid;
  logic [1:0] mode;
  logic [W-1:0] in_a, in_b;
  logic [2*W-1:0] out;
  int nvec = 0;
  int nerr = 0;

  booth_mpy_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .mode(mode),
    .in_a(in_a), .in_b(in_b), .busy(busy), .out(out), .out_valid(out_valid)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    longint sx, sy;
    x = (md == 2'd1) ? b : a;
    y = (md == 2'd2) ? a : b;
    sx = (md == 2'd0) ? longint'(x) : longint'($signed(x));
    sy = (md == 2'd0) ? longint'(y) : longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b, input bit hammer);
    logic [63:0] e;
    int cyc, idle;
    e = model(md, a, b);
    cyc = 0;
    idle = 0;
    @(negedge CLK);
    start = 1'b1; mode = md; in_a = a; in_b = b;
    @(posedge CLK); #1;
    start = hammer;
    if (hammer) in_a = 100;
    while (!out_valid && cyc < 3 * ITER) begin
      idle += busy ? 0 : 1;
      @(posedge CLK); #1;
      cyc++;
      if (hammer) begin in_b = $urandom; mode = 2'($urandom); end
    end
    chk("latency", 64'(cyc), 64'(ITER));
    chk("busy_calc", 64'(idle), 64'd0);
    chk("busy_done", 64'(busy), 64'd1);
    chk("product", out, e);
    @(posedge CLK); #1;
    start = 1'b0;
    chk("valid_pulse", 64'(out_valid), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("hold", out, e);
  endtask

  task automatic quiet(input int n);
    int v;
    v = 0;
    repeat (n) begin
      @(posedge CLK); #1;
      v += out_valid ? 1 : 0;
    end
    chk("no_extra_valid", 64'(v), 64'd0);
  endtask

  initial begin
    logic [31:0] edges [6];
    logic [31:0] ra, rb;
    edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
    reset = 1'b1; start = 1'b0; mode = 2'd0; in_a = '0; in_b = '0;
    #12;
    chk("rst_out", out, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    @(negedge CLK); reset = 1'b0;
    op(2'd3, 32'd30, 32'(-90), 1'b0);
    op(2'd2, 32'(-30), 32'd12345, 1'b0);
    op(2'd1, 32'd0, 32'(-90), 1'b0);
    op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op(2'd3, 32'h80000000, 32'h80000000, 1'b0);
    op(2'd0, 32'h80000000, 32'h80000000, 1'b0);
    op(2'd3, 32'd7, 32'd6, 1'b1);
    op(2'd3, 32'(-5), 32'd5, 1'b0);
    quiet(ITER + 2);
    for (int i = 0; i < 16; i++) begin
      ra = $urandom_range(0, 3) == 0 ? edges[$urandom_range(0, 5)] : $urandom;
      rb = $urandom_range(0, 3) == 0 ? edges[$urandom_range(0, 5)] : $urandom;
      op(2'($urandom), ra, rb, 1'($urandom_range(0, 1)));
    end
    @(negedge CLK);
    start = 1'b1; mode = 2'd3; in_a = 32'd7; in_b = 32'd6;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_out", out, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(out_valid), 64'd0);
    @(negedge CLK); reset = 1'b0;
    quiet(ITER + 3);
    op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
